// File: rtl/update_index.sv
// Row/column cursor register for the battleship board grid.
// Loads saturated next-index values while placing ships or on the player's turn.
module update_index #(
  parameter int IDX_W   = 3,
  parameter int MAX_IDX = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_next,
  input  logic [IDX_W-1:0] j_next,
  input  logic             colocation_ships_State,
  input  logic             player_turn_State,
  output logic [IDX_W-1:0] i_actual,
  output logic [IDX_W-1:0] j_actual
);

  localparam logic [IDX_W-1:0] MAX_V = IDX_W'(MAX_IDX);

  logic             en;
  logic [IDX_W-1:0] i_d, i_q;
  logic [IDX_W-1:0] j_d, j_q;

  function automatic logic [IDX_W-1:0] sat(
    input logic [IDX_W-1:0] x
  );
    return (x > MAX_V) ? MAX_V : x;
  endfunction

  assign en = colocation_ships_State | player_turn_State;

  // Row and column always move together.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (en) begin
      i_d = sat(i_next);
      j_d = sat(j_next);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i_actual = i_q;
  assign j_actual = j_q;

endmodule

// File: tb/tb_update_index.sv
// Directed bench for update_index: default 3-bit build
// and a 4-bit build with MAX_IDX=9 for saturation.
module tb_update_index;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] a_i_next, a_j_next;
  logic       a_colo, a_turn;
  logic [2:0] a_i, a_j;
  logic [3:0] b_i_next, b_j_next;
  logic       b_colo, b_turn;
  logic [3:0] b_i, b_j;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  update_index #(.IDX_W(3), .MAX_IDX(7)) dut_a (
    .clk                    (clk),
    .rst                    (rst),
    .i_next                 (a_i_next),
    .j_next                 (a_j_next),
    .colocation_ships_State (a_colo),
    .player_turn_State      (a_turn),
    .i_actual               (a_i),
    .j_actual               (a_j)
  );

  update_index #(.IDX_W(4), .MAX_IDX(9)) dut_b (
    .clk                    (clk),
    .rst                    (rst),
    .i_next                 (b_i_next),
    .j_next                 (b_j_next),
    .colocation_ships_State (b_colo),
    .player_turn_State      (b_turn),
    .i_actual               (b_i),
    .j_actual               (b_j)
  );

  task automatic check(input string tag,
                       input logic [3:0] obs,
                       input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag,
                         input logic [2:0] ei,
                         input logic [2:0] ej);
    check({tag, ".i"}, {1'b0, a_i}, {1'b0, ei});
    check({tag, ".j"}, {1'b0, a_j}, {1'b0, ej});
  endtask

  task automatic check_b(input string tag,
                         input logic [3:0] ei,
                         input logic [3:0] ej);
    check({tag, ".i"}, b_i, ei);
    check({tag, ".j"}, b_j, ej);
  endtask

  initial begin
    rst = 1'b1;
    a_colo = 1'b0; a_turn = 1'b0;
    b_colo = 1'b0; b_turn = 1'b0;
    a_i_next = 3'd5; a_j_next = 3'd3;
    b_i_next = 4'd6; b_j_next = 4'd2;

    // 1: reset, then hold at 0 with enables low
    step();
    check_a("rst_a", 3'd0, 3'd0);
    check_b("rst_b", 4'd0, 4'd0);
    rst = 1'b0;
    a_i_next = 3'd6; a_j_next = 3'd5;
    step();
    step();
    check_a("idle_after_rst", 3'd0, 3'd0);
    check_b("idle_after_rst_b", 4'd0, 4'd0);

    // 2: ship placement enable
    a_colo = 1'b1; a_i_next = 3'd2; a_j_next = 3'd2;
    step();
    check_a("colo_2_2", 3'd2, 3'd2);

    // 3: player turn enable
    a_colo = 1'b0; a_turn = 1'b1;
    a_i_next = 3'd4; a_j_next = 3'd4;
    step();
    check_a("turn_4_4", 3'd4, 3'd4);

    // 4: hold with enables low
    a_turn = 1'b0; a_i_next = 3'd0; a_j_next = 3'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_a("hold_4_4", 3'd4, 3'd4);
    end

    // 5: both enables, then reset wins
    a_colo = 1'b1; a_turn = 1'b1;
    a_i_next = 3'd7; a_j_next = 3'd1;
    step();
    check_a("both_7_1", 3'd7, 3'd1);
    a_i_next = 3'd3; a_j_next = 3'd6;
    rst = 1'b1;
    step();
    check_a("rst_wins", 3'd0, 3'd0);
    rst = 1'b0;
    step();
    check_a("after_rst_load", 3'd3, 3'd6);
    a_colo = 1'b0; a_turn = 1'b0;

    // 6: saturation in the wide build
    b_colo = 1'b1; b_i_next = 4'd12; b_j_next = 4'd9;
    step();
    check_b("sat_12_9", 4'd9, 4'd9);
    b_colo = 1'b0; b_turn = 1'b1;
    b_i_next = 4'd8; b_j_next = 4'd10;
    step();
    check_b("sat_8_10", 4'd8, 4'd9);
    b_i_next = 4'd15; b_j_next = 4'd0;
    step();
    check_b("sat_15_0", 4'd9, 4'd0);
    b_turn = 1'b0; b_i_next = 4'd1; b_j_next = 4'd1;
    step();
    check_b("hold_b", 4'd9, 4'd0);
    check_a("a_unaffected", 3'd3, 3'd6);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
